// File: rtl/timecode_keyer.sv
// Amplitude keyer for WWVB-style time code: plays a double-buffered frame of
// zero/one/marker/idle symbols as timed carrier drops on the i amplitude output.
module timecode_keyer #(
  parameter int IQW       = 8,
  parameter int MAG_H     = 160,
  parameter int MAG_L     = 127,
  parameter int MAG_Q     = 127,
  parameter int TICK_DIV  = 19231,
  parameter int SYM_TICKS = 100,
  parameter int ZERO_LOW  = 20,
  parameter int ONE_LOW   = 50,
  parameter int MARK_LOW  = 80,
  parameter int FRAME_LEN = 60
) (
  input  logic                         clk,
  input  logic                         reset_,
  input  logic                         en,
  input  logic [2*FRAME_LEN-1:0]       frame_bits,
  input  logic                         frame_valid,
  output logic                         frame_ready,
  output logic [IQW-1:0]               i,
  output logic [IQW-1:0]               q,
  output logic [$clog2(FRAME_LEN)-1:0] sym_idx,
  output logic                         sym_strobe,
  output logic                         frame_start,
  output logic                         underrun,
  output logic [1:0]                   dbg_state
);

  localparam int IW = $clog2(FRAME_LEN);
  localparam int DW = $clog2(TICK_DIV);
  localparam int TW = $clog2(SYM_TICKS);
  localparam int FW = 2 * FRAME_LEN;

  localparam logic [IQW-1:0] MAG_H_V   = IQW'(MAG_H);
  localparam logic [IQW-1:0] MAG_L_V   = IQW'(MAG_L);
  localparam logic [IQW-1:0] MAG_Q_V   = IQW'(MAG_Q);
  localparam logic [DW-1:0]  DIV_LAST  = DW'(TICK_DIV - 1);
  localparam logic [TW-1:0]  SYM_LAST  = TW'(SYM_TICKS - 1);
  localparam logic [TW-1:0]  ZERO_M1   = TW'(ZERO_LOW - 1);
  localparam logic [TW-1:0]  ONE_M1    = TW'(ONE_LOW - 1);
  localparam logic [TW-1:0]  MARK_M1   = TW'(MARK_LOW - 1);
  localparam logic [IW-1:0]  IDX_LAST  = IW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2} state_t;

  // Handshake: a frame transfers on any clk edge where frame_valid && frame_ready;
  // frame_ready is high exactly while the shadow buffer is empty.
  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [FW-1:0]   active_q, active_d;
  logic [FW-1:0]   shadow_q, shadow_d;
  logic            sfull_q, sfull_d;
  logic            ready_q, ready_d;
  logic [IQW-1:0]  i_q, i_d;
  logic [IQW-1:0]  q_q;
  logic            strobe_q, strobe_d;
  logic            fstart_q, fstart_d;
  logic            urun_q, urun_d;

  logic            tick, start, boundary, acc;
  logic [IW-1:0]   nxt_idx;
  logic [FW-1:0]   frame_sel;
  logic [1:0]      cur_sym, new_sym;
  logic [TW-1:0]   low_m1;

  assign tick    = (div_q == DIV_LAST);
  assign acc     = frame_valid && ready_q;
  assign cur_sym = active_q[{idx_q, 1'b0} +: 2];

  always_comb begin
    low_m1 = MARK_M1;
    case (cur_sym)
      2'b00:   low_m1 = ZERO_M1;
      2'b01:   low_m1 = ONE_M1;
      default: low_m1 = MARK_M1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    tick_d    = tick_q;
    idx_d     = idx_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    sfull_d   = sfull_q;
    i_d       = i_q;
    strobe_d  = 1'b0;
    fstart_d  = 1'b0;
    urun_d    = 1'b0;
    start     = 1'b0;
    boundary  = 1'b0;
    nxt_idx   = '0;
    frame_sel = active_q;
    new_sym   = 2'b11;

    if (!en) begin
      state_d  = IDLE;
      i_d      = MAG_H_V;
      idx_d    = '0;
      div_d    = '0;
      tick_d   = '0;
      active_d = '1;
    end else begin
      case (state_q)
        IDLE: begin
          start    = 1'b1;
          boundary = 1'b1;
        end
        LOW, HIGH: begin
          div_d = tick ? '0 : div_q + DW'(1);
          if (tick) begin
            if (tick_q == SYM_LAST) begin
              start = 1'b1;
              if (idx_q == IDX_LAST) boundary = 1'b1;
              else                   nxt_idx  = idx_q + IW'(1);
            end else begin
              tick_d = tick_q + TW'(1);
              // Low phase ends on the edge that completes the LOWLEN-th tick.
              if (state_q == LOW && tick_q == low_m1) begin
                i_d     = MAG_H_V;
                state_d = HIGH;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (start) begin
      if (boundary) begin
        frame_sel = sfull_q ? shadow_q : '1;
        active_d  = frame_sel;
        sfull_d   = 1'b0;
        urun_d    = !sfull_q;
      end
      new_sym  = frame_sel[{nxt_idx, 1'b0} +: 2];
      idx_d    = nxt_idx;
      div_d    = '0;
      tick_d   = '0;
      strobe_d = 1'b1;
      fstart_d = (nxt_idx == '0);
      if (new_sym == 2'b11) begin
        i_d     = MAG_H_V;
        state_d = HIGH;
      end else begin
        i_d     = MAG_L_V;
        state_d = LOW;
      end
    end

    // A frame accepted on a boundary edge lands after the copy, so it waits a full frame.
    if (acc) begin
      shadow_d = frame_bits;
      sfull_d  = 1'b1;
    end
    ready_d = !sfull_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q  <= IDLE;
      div_q    <= '0;
      tick_q   <= '0;
      idx_q    <= '0;
      active_q <= '0;
      shadow_q <= '0;
      sfull_q  <= 1'b0;
      ready_q  <= 1'b1;
      i_q      <= MAG_H_V;
      q_q      <= MAG_Q_V;
      strobe_q <= 1'b0;
      fstart_q <= 1'b0;
      urun_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      tick_q   <= tick_d;
      idx_q    <= idx_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      sfull_q  <= sfull_d;
      ready_q  <= ready_d;
      i_q      <= i_d;
      q_q      <= MAG_Q_V;
      strobe_q <= strobe_d;
      fstart_q <= fstart_d;
      urun_q   <= urun_d;
    end
  end

  assign frame_ready = ready_q;
  assign i           = i_q;
  assign q           = q_q;
  assign sym_idx     = idx_q;
  assign sym_strobe  = strobe_q;
  assign frame_start = fstart_q;
  assign underrun    = urun_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_timecode_keyer.sv
// Directed bench for timecode_keyer: table of frames played back-to-back, then
// hand-written sequences for boundary handshake, mid-frame reset and enable drop.
module tb_timecode_keyer;

  localparam int FL     = 4;
  localparam int IW     = $clog2(FL);
  localparam int SYM_CY = 40;
  localparam int HI     = 160;
  localparam int LO     = 127;

  logic          clk = 1'b0;
  logic          reset_ = 1'b0;
  logic          en = 1'b0;
  logic [7:0]    frame_bits = '0;
  logic          frame_valid = 1'b0;
  logic          frame_ready;
  logic [7:0]    i_out, q_out;
  logic [IW-1:0] sym_idx;
  logic          sym_strobe, frame_start, underrun;
  logic [1:0]    dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  timecode_keyer #(
    .IQW(8), .MAG_H(160), .MAG_L(127), .MAG_Q(127), .TICK_DIV(4), .SYM_TICKS(10),
    .ZERO_LOW(2), .ONE_LOW(5), .MARK_LOW(8), .FRAME_LEN(FL)
  ) dut (
    .clk(clk), .reset_(reset_), .en(en), .frame_bits(frame_bits),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .i(i_out), .q(q_out),
    .sym_idx(sym_idx), .sym_strobe(sym_strobe), .frame_start(frame_start),
    .underrun(underrun), .dbg_state(dbg_state)
  );

  typedef struct {
    logic [7:0] frame;
    bit         load;
    bit         ur;
    int         lows[4];
  } rec_t;

  rec_t vec[5];

  function automatic rec_t mk(input logic [7:0] f, input bit ld, input bit ur,
                              input int l0, input int l1, input int l2, input int l3);
    rec_t r;
    r.frame = f; r.load = ld; r.ur = ur;
    r.lows[0] = l0; r.lows[1] = l1; r.lows[2] = l2; r.lows[3] = l3;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int c = 0; c < n; c++) tick();
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b);
    frame_bits  = b;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
  endtask

  // Plays one full frame starting with the edge that begins symbol 0.
  task automatic run_frame(input string tag, input rec_t r, input bit pend,
                           input bit load_next, input logic [7:0] next_bits, input int load_pos);
    int low_cnt, first_high, strobe_err, idx_err, ready_err, misc_err, k;
    bit exp_ready;
    for (int s = 0; s < FL; s++) begin
      low_cnt = 0; first_high = -1; strobe_err = 0; idx_err = 0; ready_err = 0; misc_err = 0;
      for (int o = 0; o < SYM_CY; o++) begin
        k = s * SYM_CY + o;
        tick();
        frame_valid = 1'b0;
        if (i_out == 8'(LO)) low_cnt++;
        else if (i_out == 8'(HI) && first_high < 0) first_high = o;
        else if (i_out != 8'(HI)) misc_err++;
        if (sym_strobe != (o == 0)) strobe_err++;
        if (int'(sym_idx) != s) idx_err++;
        exp_ready = !(pend || (load_next && k > load_pos));
        if (frame_ready != exp_ready) ready_err++;
        if (q_out != 8'd127) misc_err++;
        if (k == 0) begin
          check($sformatf("%s frame_start", tag), int'(frame_start), 1);
          check($sformatf("%s underrun", tag), int'(underrun), int'(r.ur));
        end else if (frame_start || underrun) misc_err++;
        if (load_next && k == load_pos) begin
          frame_bits  = next_bits;
          frame_valid = 1'b1;
        end
      end
      check($sformatf("%s sym%0d low_cycles", tag, s), low_cnt, r.lows[s]);
      check($sformatf("%s sym%0d first_high", tag, s), first_high, r.lows[s]);
      check($sformatf("%s sym%0d strobe_errs", tag, s), strobe_err, 0);
      check($sformatf("%s sym%0d idx_errs", tag, s), idx_err, 0);
      check($sformatf("%s sym%0d ready_errs", tag, s), ready_err, 0);
      check($sformatf("%s sym%0d misc_errs", tag, s), misc_err, 0);
    end
  endtask

  initial begin
    // frame_bits[2k+1:2k] is symbol k; lows are hand-computed low-cycle counts (ticks*4)
    vec[0] = mk(8'hC6, 1'b1, 1'b0, 32, 20,  8,  0);  // marker, one, zero, idle
    vec[1] = mk(8'h90, 1'b1, 1'b0,  8,  8, 20, 32);  // zero, zero, one, marker
    vec[2] = mk(8'h7B, 1'b1, 1'b0,  0, 32,  0, 20);  // idle, marker, idle, one
    vec[3] = mk(8'h55, 1'b1, 1'b0, 20, 20, 20, 20);  // one x4
    vec[4] = mk(8'hFF, 1'b0, 1'b1,  0,  0,  0,  0);  // nothing loaded: underrun, idle frame

    reset_ = 1'b0;
    cycles(3);
    check("reset i", int'(i_out), HI);
    check("reset q", int'(q_out), 127);
    check("reset frame_ready", int'(frame_ready), 1);
    check("reset sym_idx", int'(sym_idx), 0);
    check("reset strobes", int'(sym_strobe) + int'(frame_start) + int'(underrun), 0);
    check("reset state", int'(dbg_state), 0);
    reset_ = 1'b1;
    cycles(2);
    check("idle i with en=0", int'(i_out), HI);

    send_frame(vec[0].frame);
    check("ready after preload", int'(frame_ready), 0);
    en = 1'b1;
    for (int v = 0; v < 5; v++) begin
      if (v < 4 && vec[v + 1].load)
        run_frame($sformatf("vec%0d", v), vec[v], 1'b0, 1'b1, vec[v + 1].frame, 5);
      else
        run_frame($sformatf("vec%0d", v), vec[v], 1'b0, 1'b0, 8'h00, 0);
    end

    // Handshake on the exact boundary edge with shadow empty
    run_frame("bnd_pre", vec[4], 1'b0, 1'b1, 8'h90, SYM_CY * FL - 1);
    run_frame("bnd_idle", vec[4], 1'b1, 1'b0, 8'h00, 0);
    run_frame("bnd_sent", vec[1], 1'b0, 1'b0, 8'h00, 0);

    // Reset in the low phase of symbol 2
    en = 1'b0;
    cycles(1);
    check("en low state", int'(dbg_state), 0);
    send_frame(8'h90);
    en = 1'b1;
    cycles(1);
    check("rst_mid start i", int'(i_out), LO);
    cycles(60);
    send_frame(8'h55);
    check("rst_mid shadow full", int'(frame_ready), 0);
    cycles(24);
    check("rst_mid sym2 low", int'(i_out), LO);
    check("rst_mid sym_idx", int'(sym_idx), 2);
    reset_ = 1'b0;
    en     = 1'b0;
    cycles(1);
    check("rst_mid i", int'(i_out), HI);
    check("rst_mid sym_idx0", int'(sym_idx), 0);
    check("rst_mid ready", int'(frame_ready), 1);
    check("rst_mid state", int'(dbg_state), 0);
    check("rst_mid strobes", int'(sym_strobe) + int'(frame_start) + int'(underrun), 0);
    reset_ = 1'b1;
    en     = 1'b1;
    cycles(1);
    check("rst_mid shadow cleared underrun", int'(underrun), 1);
    check("rst_mid restart frame_start", int'(frame_start), 1);
    check("rst_mid restart i", int'(i_out), HI);

    // Enable dropped mid-symbol, shadow survives
    en = 1'b0;
    cycles(1);
    send_frame(8'hC6);
    en = 1'b1;
    cycles(1);
    check("en_drop A start underrun", int'(underrun), 0);
    check("en_drop A marker low", int'(i_out), LO);
    cycles(50);
    send_frame(8'h90);
    check("en_drop sym1 low", int'(i_out), LO);
    check("en_drop sym_idx1", int'(sym_idx), 1);
    check("en_drop B stored", int'(frame_ready), 0);
    en = 1'b0;
    cycles(1);
    check("en_drop i", int'(i_out), HI);
    check("en_drop sym_idx0", int'(sym_idx), 0);
    check("en_drop state", int'(dbg_state), 0);
    cycles(3);
    check("en_drop i held", int'(i_out), HI);
    check("en_drop shadow kept", int'(frame_ready), 0);
    en = 1'b1;
    run_frame("en_restart", vec[1], 1'b0, 1'b0, 8'h00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
